iob_2p_fifo: RTL and testbench
==============================

// Module: iob_2p_fifo
//
// PURPOSE
//  Synchronous single-clock FIFO built on two-port RAM storage (one write port, one read port).
//  Capacity is 2**ADDR_W words of DATA_W bits.
//  Adds what bare 2-port memory lacks: pointer management, full/empty flags, occupancy level, overflow/underflow protection.
//  Sits between producer/consumer datapaths in the same clock domain (UART, DMA, stream buffers).
//
// PARAMETERS
//  DATA_W   8  word width in bits
//  ADDR_W   4  log2 of depth; depth = 2**ADDR_W
//  USE_RAM  0  storage style: 0 = plain registered read; 1 = RAM with read enable (data_out changes only on accepted read)
//
// PORTS
//  clk       in   1         clock; all logic on rising edge
//  rst       in   1         synchronous reset, active-high
//  w_en      in   1         write request
//  data_in   in   DATA_W    write data
//  full      out  1         no free location
//  r_en      in   1         read request
//  data_out  out  DATA_W    read data
//  empty     out  1         no readable word
//  level     out  ADDR_W+1  words stored, 0..2**ADDR_W
//
// BEHAVIOUR
//  - Reset (rst=1 at an edge): pointers=0, level=0, empty=1, full=0, data_out=0; contents undefined. Overrides any concurrent w_en/r_en; mid-stream reset discards all words.
//  - Write accepted iff w_en && !full (flags as seen before the edge); data_in stored at wr_ptr, wr_ptr+1.
//  - Read accepted iff r_en && !empty; rd_ptr+1.
//  - Rejected requests: no state change, no error signal; data_out holds.
//  - Pointers ADDR_W bits, wrap 2**ADDR_W-1 -> 0 silently.
//  - level: +1 write only; -1 read only; unchanged on both or neither.
//  - full = (level == 2**ADDR_W); empty = (level == 0); both registered/derived from level, no combinational path from w_en/r_en.
//  - Simultaneous w_en && r_en:
//      - when full: only the read is accepted; level -1.
//      - when empty: only the write is accepted; level +1 (no write-through to data_out).
//      - otherwise: both accepted; level unchanged.
//  - Standard mode read latency is 1 cycle: word popped at edge k appears on data_out after edge k and holds until the next accepted read.
//  - Write-to-readable latency is 1 cycle: empty drops after the write edge.
//
// CONFIGURATION
//  Macro IOB_2P_FIFO_FWFT_EN (first-word-fall-through):
//  - Undefined: behaviour as above.
//  - Defined:
//      - 1-word output register prefetches the head word.
//      - data_out shows the head word whenever empty=0.
//      - r_en && !empty consumes it; the next word appears after the same edge when available.
//      - A word written into an empty FIFO at edge k is visible with empty=0 after edge k+2.
//      - level counts memory plus output register; capacity stays 2**ADDR_W.
//      - data_out is don't-care while empty=1.
//
// STRUCTURE
//  - No package needed. Local constants: DEPTH = 2**ADDR_W and level width ADDR_W+1, shared by full/empty compares.
//  - One sub-module: iob_2p_mem (DATA_W, ADDR_W, USE_RAM), driven with w_en = accepted write and r_en = accepted read (or prefetch under FWFT).
//  - Pointer/level/flag logic and the optional prefetch register live in this file.
//
// TESTING (DATA_W=8, ADDR_W=4; run USE_RAM=0 and 1, with and without IOB_2P_FIFO_FWFT_EN)
//  1. After reset, 16 writes of 32..47 -> level counts 1..16, full=1 after the 16th; 17th write of 99 is ignored and level stays 16.
//  2. 16 reads -> data_out 32..47 in order, empty=1 after the last; an extra read leaves data_out=47 (non-FWFT) and level=0.
//  3. Steady stream of 40 words with simultaneous w_en/r_en at level 5 -> pointers wrap, output sequence intact, level stays 5.
//  4. Full with both w_en=1 (data 0xAA) and r_en=1 -> read served, 0xAA not stored, level 15; empty with both -> word stored, level 1, data_out unchanged.
//  5. rst=1 at level 9 while w_en=r_en=1 -> level=0, empty=1, full=0, data_out=0 next cycle; the next write/read pair returns the new word.
//  6. FWFT only: write 0x5C into an empty FIFO at edge k -> empty=0, data_out=0x5C after edge k+2 with no r_en.

Source files
------------

// File: rtl/iob_2p_mem.sv
// Two-port storage for iob_2p_fifo: one write port, one read port with read enable.
// USE_RAM=1 models a RAM macro whose read register has no reset (masked to zero until first read).
module iob_2p_mem #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int USE_RAM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (w_en) mem_q[w_addr] <= w_data;
  end

  if (USE_RAM != 0) begin : g_ram
    logic [DATA_W-1:0] rd_q;
    logic              rd_vld_q;
    always_ff @(posedge clk) begin
      if (r_en) rd_q <= mem_q[r_addr];
    end
    // Macro output register has no reset, so hide its contents until the first read.
    always_ff @(posedge clk) begin
      if (rst)       rd_vld_q <= 1'b0;
      else if (r_en) rd_vld_q <= 1'b1;
    end
    assign r_data = rd_vld_q ? rd_q : '0;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (rst)       rd_q <= '0;
      else if (r_en) rd_q <= mem_q[r_addr];
    end
    assign r_data = rd_q;
  end
endmodule

// File: rtl/iob_2p_fifo.sv
// Single-clock FIFO over iob_2p_mem with pointers, level and full/empty flags.
// Define IOB_2P_FIFO_FWFT_EN for first-word-fall-through output.
module iob_2p_fifo #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int USE_RAM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  input  logic              r_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LVL_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wr_acc, rd_acc, mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign level  = level_q;
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_comb begin
    level_d  = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + ADDR_W'(mem_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef IOB_2P_FIFO_FWFT_EN
  // Prefetch path: RAM read register (mid stage) feeds the head-word register.
  logic [LVL_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              mid_vld_q, mid_vld_d, out_vld_q, out_vld_d, mid_adv;
  logic [DATA_W-1:0] out_q, out_d;

  always_comb begin
    mid_adv   = mid_vld_q && (!out_vld_q || rd_acc);
    mem_rd    = (mem_cnt_q != '0) && (!mid_vld_q || mid_adv);
    mem_cnt_d = mem_cnt_q + LVL_W'(wr_acc) - LVL_W'(mem_rd);
    mid_vld_d = mem_rd || (mid_vld_q && !mid_adv);
    out_vld_d = mid_adv || (out_vld_q && !rd_acc);
    out_d     = mid_adv ? mem_rdata : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_cnt_q <= '0;
      mid_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      mid_vld_q <= mid_vld_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  assign empty    = !out_vld_q;
  assign data_out = out_q;
`else
  assign mem_rd   = rd_acc;
  assign empty    = (level_q == '0);
  assign data_out = mem_rdata;
`endif

  iob_2p_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .USE_RAM(USE_RAM)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .w_en  (wr_acc),
    .w_addr(wr_ptr_q),
    .w_data(data_in),
    .r_en  (mem_rd),
    .r_addr(rd_ptr_q),
    .r_data(mem_rdata)
  );
endmodule

// File: tb/tb_iob_2p_fifo.sv
// Randomized self-checking bench for iob_2p_fifo against a queue-based reference model.
module tb_iob_2p_fifo;
  localparam int USE_RAM = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       full, empty;
  logic [4:0] level;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] q[$];
  int         qt[$];
  logic [7:0] dout_m = '0;

  always #5 clk = ~clk;

  iob_2p_fifo #(.DATA_W(8), .ADDR_W(4), .USE_RAM(USE_RAM)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .full(full),
    .r_en(r_en), .data_out(data_out), .empty(empty), .level(level)
  );

  // FWFT: the head word is presented two edges after it was written.
  function automatic bit m_empty();
    if (q.size() == 0) return 1'b1;
`ifdef IOB_2P_FIFO_FWFT_EN
    return (cyc - qt[0]) < 2;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [6:0] exp_flags();
    return {5'(q.size()), q.size() == 16, m_empty()};
  endfunction

  function automatic logic [7:0] exp_data();
`ifdef IOB_2P_FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : 8'h00;
`else
    return dout_m;
`endif
  endfunction

  function automatic bit data_valid();
`ifdef IOB_2P_FIFO_FWFT_EN
    return !m_empty();
`else
    return 1'b1;
`endif
  endfunction

  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit wa, ra;
    wa = w && (q.size() != 16);
    ra = r && !m_empty();
    w_en = w; data_in = d; r_en = r;
    @(posedge clk);
    cyc++;
    if (ra) begin dout_m = q.pop_front(); void'(qt.pop_front()); end
    if (wa) begin q.push_back(d); qt.push_back(cyc); end
    #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst = 1'b1; w_en = w; r_en = r; data_in = 8'h77;
    @(posedge clk);
    cyc++;
    q.delete(); qt.delete(); dout_m = '0;
    #1;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if ({level, full, empty, data_out} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset: got level=%0d full=%b empty=%b data=%h, want 0/0/1/00", level, full, empty, data_out);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, (i < 16) ? 8'(32 + i) : 8'd99, 1'b0);
      checks++;
      if ({level, full, empty} !== exp_flags()) begin
        errors++;
        $display("FAIL fill[%0d]: got lvl/full/empty=%0d/%b/%b, want %h", i, level, full, empty, exp_flags());
      end
    end
    checks++;
    if (level !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_overflow: got level=%0d full=%b, want 16/1", level, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 17; i++) begin
      if (data_valid()) begin
        checks++;
        if (data_out !== exp_data()) begin
          errors++;
          $display("FAIL drain_pre[%0d]: got data=%h want %h", i, data_out, exp_data());
        end
      end
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if ({level, full, empty} !== exp_flags() || (data_valid() && data_out !== exp_data())) begin
        errors++;
        $display("FAIL drain[%0d]: got lvl=%0d full=%b empty=%b data=%h, want %h data %h", i, level, full, empty, data_out, exp_flags(), exp_data());
      end
    end
`ifndef IOB_2P_FIFO_FWFT_EN
    checks++;
    if (data_out !== 8'd47 || level !== 5'd0) begin
      errors++;
      $display("FAIL underflow_hold: got data=%h level=%0d, want 2f/0", data_out, level);
    end
`endif
  endtask

  task automatic test_stream();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1);
      checks++;
      if (level !== 5'd5 || {level, full, empty} !== exp_flags() || (data_valid() && data_out !== exp_data())) begin
        errors++;
        $display("FAIL stream[%0d]: got lvl=%0d empty=%b data=%h, want %h data %h", i, level, empty, data_out, exp_flags(), exp_data());
      end
    end
  endtask

  task automatic test_both_edges();
    logic [7:0] held;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 169)), 1'b0);
    cycle(1'b1, 8'hAA, 1'b1);
    checks++;
    if (level !== 5'd15 || {level, full, empty} !== exp_flags() || (data_valid() && data_out !== exp_data())) begin
      errors++;
      $display("FAIL full_both: got lvl=%0d full=%b data=%h, want 15 data %h", level, full, data_out, exp_data());
    end
    for (int i = 0; i < 17; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if ((data_valid() && data_out === 8'hAA) || (data_valid() && data_out !== exp_data())) begin
        errors++;
        $display("FAIL full_both_drain[%0d]: got data=%h want %h", i, data_out, exp_data());
      end
    end
    held = data_out;
    cycle(1'b1, 8'h3C, 1'b1);
    checks++;
    if (level !== 5'd1 || {level, full, empty} !== exp_flags()) begin
      errors++;
      $display("FAIL empty_both: got lvl=%0d empty=%b, want 1 %h", level, empty, exp_flags());
    end
`ifndef IOB_2P_FIFO_FWFT_EN
    checks++;
    if (data_out !== held) begin
      errors++;
      $display("FAIL empty_both_hold: got data=%h want %h", data_out, held);
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic [7:0] nw;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'($urandom), 1'b0);
    do_reset(1'b1, 1'b1);
    checks++;
    if ({level, full, empty, data_out} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL mid_reset: got level=%0d full=%b empty=%b data=%h, want 0/0/1/00", level, full, empty, data_out);
    end
    nw = 8'($urandom_range(1, 255));
    cycle(1'b1, nw, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
`ifdef IOB_2P_FIFO_FWFT_EN
    checks++;
    if (empty !== 1'b0 || data_out !== nw) begin
      errors++;
      $display("FAIL mid_reset_word: got empty=%b data=%h want 0 %h", empty, data_out, nw);
    end
`endif
    cycle(1'b0, 8'h00, 1'b1);
`ifndef IOB_2P_FIFO_FWFT_EN
    checks++;
    if (data_out !== nw) begin
      errors++;
      $display("FAIL mid_reset_word: got data=%h want %h", data_out, nw);
    end
`endif
    checks++;
    if ({level, full, empty} !== {5'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_after: got lvl=%0d empty=%b want 0/1", level, empty);
    end
  endtask

`ifdef IOB_2P_FIFO_FWFT_EN
  task automatic test_fwft_latency();
    do_reset(1'b0, 1'b0);
    cycle(1'b1, 8'h5C, 1'b0);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fwft_k: got empty=%b want 1", empty); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL fwft_k1: got empty=%b want 1", empty); end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (empty !== 1'b0 || data_out !== 8'h5C || level !== 5'd1) begin
      errors++;
      $display("FAIL fwft_k2: got empty=%b data=%h level=%0d want 0/5c/1", empty, data_out, level);
    end
  endtask
`endif

  task automatic test_random();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45));
      checks++;
      if ({level, full, empty} !== exp_flags() || (data_valid() && data_out !== exp_data())) begin
        errors++;
        $display("FAIL random[%0d]: got lvl=%0d full=%b empty=%b data=%h, want %h data %h", i, level, full, empty, data_out, exp_flags(), exp_data());
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_both_edges();
    test_mid_reset();
`ifdef IOB_2P_FIFO_FWFT_EN
    test_fwft_latency();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
